data_sram_resp: RTL

DATA_SRAM_RESP -- requirements
Module: data_sram_resp

---
 rtl/data_sram_resp.sv | 130 +++++++++++++
 1 files changed

// File: rtl/data_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module      : data_sram_resp
//  Description : Data-side SRAM responder for the MEM stage. Single-port
//                word memory with byte write enables, 1-cycle registered
//                read data, and an optional fixed number of stall cycles
//                per request (WAIT_CYCLES) signalled through stallreq.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_sram_resp #(
    parameter int ADDR_WD     = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        stallreq
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;
    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);

    logic [0:0]         r_state;
    logic [3:0]         r_cnt;
    logic [31:0]        r_mem [0:(1 << ADDR_WD) - 1];
    logic [31:0]        r_rdata;
    logic               r_rdata_valid;

    logic [0:0]         w_state_nxt;
    logic [3:0]         w_cnt_nxt;
    logic               w_stall;
    logic               w_access;
    logic               w_do_access;
    logic               w_do_read;
    logic [ADDR_WD-1:0] w_idx;
    logic               w_unused_addr_bits;

    // Word index; byte offset and bits above the memory depth alias away.
    assign w_idx              = data_sram_addr[ADDR_WD+1:2];
    assign w_unused_addr_bits = ^{data_sram_addr[31:ADDR_WD+2], data_sram_addr[1:0]};

    // Next-state, stall and access decode for the wait-state FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (data_sram_en) begin
                    if (c_WAIT == 4'd0) begin
                        w_access = 1'b1;
                    end else begin
                        // First cycle of a waited request only stalls.
                        w_stall     = 1'b1;
                        w_state_nxt = c_BUSY;
                        w_cnt_nxt   = c_WAIT - 4'd1;
                    end
                end
            end
            c_BUSY: begin
                if (!data_sram_en) begin
                    // Requester withdrew: abandon without touching memory.
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt != 4'd0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 4'd1;
                end else begin
                    // Wait elapsed: perform the held request this cycle.
                    w_access    = 1'b1;
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Reset masks both the stall and any access completing on that edge.
    assign stallreq    = w_stall & resetn;
    assign w_do_access = w_access & resetn;
    assign w_do_read   = w_do_access & (data_sram_wen == 4'b0000);

    // FSM state and wait counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Byte-lane writes; memory contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_do_access && data_sram_wen[i]) begin
                r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    // Registered read data and its one-cycle valid pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rdata       <= 32'd0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= w_do_read;
            if (w_do_read) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    assign data_sram_rdata = r_rdata;
    assign rdata_valid     = r_rdata_valid;

endmodule
`default_nettype wire
